// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational IF-stage lookup, ID-stage training
// with 2-bit saturating direction counters, and saturating hit/mispredict statistics.
module branch_target_buffer #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  lk_pc,
    input  logic               lk_valid,
    output logic               lk_hit,
    output logic               lk_taken,
    output logic [ADDR_W-1:0]  lk_target,
    input  logic               upd_valid,
    input  logic [ADDR_W-1:0]  upd_pc,
    input  logic               upd_taken,
    input  logic [ADDR_W-1:0]  upd_target,
    input  logic               upd_mispredict,
    input  logic               flush_all,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 1 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [COUNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [COUNT_W-1:0] misp_cnt_q, misp_cnt_d;

    logic [IDX_W-1:0] lk_idx, u_idx;
    logic [TAG_W-1:0] lk_tag, u_tag;
    logic             u_match, u_write;
    logic [1:0]       ctr_d;
    logic             unused_pc_lsb;

    assign lk_idx = lk_pc[IDX_W:1];
    assign lk_tag = lk_pc[ADDR_W-1:IDX_W+1];
    assign u_idx  = upd_pc[IDX_W:1];
    assign u_tag  = upd_pc[ADDR_W-1:IDX_W+1];
    assign unused_pc_lsb = lk_pc[0] ^ upd_pc[0];

    // Outputs are forced quiet while rst is held, before the array has been cleared.
    assign lk_hit    = !rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && ctr_q[lk_idx][1];
    assign lk_target = lk_hit ? target_q[lk_idx] : '0;

    assign u_match = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    // Hits always train; misses allocate only when taken.
    assign u_write = upd_valid && !flush_all && (u_match || upd_taken);

    always_comb begin
        ctr_d = 2'b10;
        if (u_match) begin
            ctr_d = ctr_q[u_idx];
            if (upd_taken && ctr_q[u_idx] != 2'b11) begin
                ctr_d = ctr_q[u_idx] + 2'b01;
            end else if (!upd_taken && ctr_q[u_idx] != 2'b00) begin
                ctr_d = ctr_q[u_idx] - 2'b01;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            assign valid_d[gi] = !flush_all &&
                                 (valid_q[gi] || (u_write && (u_idx == IDX_W'(gi))));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && u_write) begin
            tag_q[u_idx] <= u_tag;
            ctr_q[u_idx] <= ctr_d;
            if (upd_taken) begin
                target_q[u_idx] <= upd_target;
            end
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        misp_cnt_d = misp_cnt_q;
        if (lk_valid && lk_hit && hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + COUNT_W'(1);
        end
        if (upd_valid && upd_mispredict && misp_cnt_q != '1) begin
            misp_cnt_d = misp_cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            misp_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign hit_count        = rst ? '0 : hit_cnt_q;
    assign mispredict_count = rst ? '0 : misp_cnt_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench: one default-sized BTB plus two COUNT_W=4 copies at ENTRIES=2 and 256,
// all driven from the same stimulus.
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] lk_pc, upd_pc, upd_target;
    logic        lk_valid, upd_valid, upd_taken, upd_mispredict, flush_all;

    logic        hit_a, taken_a;
    logic [15:0] target_a, hitc_a, mispc_a;
    logic        hit_b, taken_b;
    logic [15:0] target_b;
    logic [3:0]  hitc_b, mispc_b;
    logic        hit_c, taken_c;
    logic [15:0] target_c;
    logic [3:0]  hitc_c, mispc_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ADDR_W(16), .ENTRIES(16), .COUNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_valid(lk_valid),
        .lk_hit(hit_a), .lk_taken(taken_a), .lk_target(target_a),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_all(flush_all), .hit_count(hitc_a), .mispredict_count(mispc_a));

    branch_target_buffer #(.ADDR_W(16), .ENTRIES(2), .COUNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_valid(lk_valid),
        .lk_hit(hit_b), .lk_taken(taken_b), .lk_target(target_b),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_all(flush_all), .hit_count(hitc_b), .mispredict_count(mispc_b));

    branch_target_buffer #(.ADDR_W(16), .ENTRIES(256), .COUNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_valid(lk_valid),
        .lk_hit(hit_c), .lk_taken(taken_c), .lk_target(target_c),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_all(flush_all), .hit_count(hitc_c), .mispredict_count(mispc_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("[TB] check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
    endtask

    task automatic look(input logic [15:0] pc);
        lk_pc = pc;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held two cycles with an update pending; it must be discarded.
        rst = 1'b1; lk_valid = 1'b1; flush_all = 1'b0; upd_mispredict = 1'b1;
        upd(16'h0010, 1'b1, 16'h0040);
        look(16'h0010);
        chk("rst_hold_hit", hit_a, 0);
        chk("rst_hold_tgt", target_a, 0);
        tick(); tick();
        rst = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        for (int a = 0; a <= 16'h3E; a += 2) begin
            look(16'(a));
            chk($sformatf("rst_sweep_%02h", a), hit_a, 0);
        end
        tick();
        lk_valid = 1'b0;
        chk("rst_hitc", hitc_a, 0);
        chk("rst_mispc", mispc_a, 0);
        chk("rst_mispc_e2", mispc_b, 0);

        // Allocate then train the counter through both saturation points.
        upd(16'h0010, 1'b1, 16'h0040); look(16'h0010); tick();
        upd(16'h0010, 1'b0, 16'h0BAD); #1;
        chk("alloc_hit", hit_a, 1);
        chk("alloc_taken", taken_a, 1);
        chk("alloc_tgt", target_a, 16'h0040);
        chk("alloc_hit_e2", hit_b, 1);
        chk("alloc_tgt_e256", target_c, 16'h0040);
        tick();
        chk("nt1_taken", taken_a, 0);
        chk("nt1_tgt", target_a, 16'h0040);
        tick();
        chk("nt2_hit", hit_a, 1);
        chk("nt2_taken", taken_a, 0);
        tick();
        upd(16'h0010, 1'b1, 16'h0044); #1;
        chk("nt3_taken", taken_a, 0);
        tick();
        chk("t1_taken", taken_a, 0);
        chk("t1_tgt", target_a, 16'h0044);
        tick();
        chk("t2_taken", taken_a, 1);
        tick(); tick();
        upd(16'h0010, 1'b0, 16'h0000); #1;
        chk("t4_taken", taken_a, 1);
        tick();
        chk("sat_nt1_taken", taken_a, 1);
        tick();
        upd_valid = 1'b0; #1;
        chk("sat_nt2_taken", taken_a, 0);

        // Aliasing on index 8: 0x0030 evicts 0x0010; a not-taken miss allocates nothing.
        upd(16'h0030, 1'b1, 16'h0100); tick();
        upd(16'h0050, 1'b0, 16'h0200); look(16'h0010);
        chk("alias_old_hit", hit_a, 0);
        tick();
        upd_valid = 1'b0;
        look(16'h0030);
        chk("alias_new_hit", hit_a, 1);
        chk("alias_new_tgt", target_a, 16'h0100);
        chk("alias_new_tkn", taken_a, 1);
        look(16'h0050);
        chk("nt_miss_hit", hit_a, 0);

        // Same-cycle lookup and first-time update: no bypass.
        upd(16'h0020, 1'b1, 16'h0200); look(16'h0020);
        chk("hazard_pre_hit", hit_a, 0);
        tick();
        upd_valid = 1'b0; #1;
        chk("hazard_post_hit", hit_a, 1);
        chk("hazard_post_tgt", target_a, 16'h0200);
        look(16'h0021);
        chk("lsb_ignored", hit_a, 1);

        // Hit counter: three qualified hits, two qualified misses, two unqualified hits.
        lk_valid = 1'b1; look(16'h0020); tick(); tick(); tick();
        look(16'h0040); tick(); tick();
        lk_valid = 1'b0; look(16'h0020); tick(); tick();
        chk("hit_count", hitc_a, 3);

        // Four valid entries, then flush with a same-cycle taken update that must be dropped.
        upd(16'h0004, 1'b1, 16'h0300); tick();
        upd(16'h0006, 1'b1, 16'h0302); tick();
        upd_valid = 1'b0; look(16'h0006);
        chk("pre_flush_hit", hit_a, 1);
        upd(16'h0008, 1'b1, 16'h0304); flush_all = 1'b1; tick();
        upd_valid = 1'b0; flush_all = 1'b0;
        look(16'h0020); chk("flush_20", hit_a, 0);
        look(16'h0030); chk("flush_30", hit_a, 0);
        look(16'h0004); chk("flush_04", hit_a, 0);
        look(16'h0006); chk("flush_06", hit_a, 0);
        look(16'h0008); chk("flush_upd_08", hit_a, 0);
        chk("flush_hitc", hitc_a, 3);

        // Mispredict counter saturation on the COUNT_W=4 copies.
        upd(16'h000C, 1'b0, 16'h0000); upd_mispredict = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("misp10_a", mispc_a, 10);
        chk("misp10_e2", mispc_b, 10);
        for (int i = 0; i < 10; i++) tick();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
        tick();
        chk("misp20_a", mispc_a, 20);
        chk("misp_sat_e2", mispc_b, 15);
        chk("misp_sat_e256", mispc_c, 15);
        look(16'h000C);
        chk("nt_no_alloc", hit_a, 0);

        // Reset in the middle of training drops the in-flight allocate and clears counters.
        rst = 1'b1; upd(16'h000A, 1'b1, 16'h0400); tick();
        rst = 1'b0; upd_valid = 1'b0; look(16'h000A);
        chk("mid_rst_hit", hit_a, 0);
        chk("mid_rst_hitc", hitc_a, 0);
        chk("mid_rst_mispc", mispc_a, 0);
        chk("mid_rst_misp_e2", mispc_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
